// File: rtl/irq_bank_prio_if.sv
// Request/grant bundle between the interrupt sources and irq_bank_prio_ctrl.
// The master modport drives requests, mask and ack; the slave modport presents the winner.
interface irq_bank_prio_if #(
    parameter int NUM_CH    = 9,
    parameter int NUM_BANKS = 3
);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int NUM_LINES = NUM_BANKS * NUM_CH;

    logic [NUM_LINES-1:0] irq_in;
    logic [NUM_BANKS-1:0] bank_en;
    logic                 mask_we;
    logic [NUM_LINES-1:0] mask_wdata;
    logic                 irq_valid;
    logic [BANK_W-1:0]    irq_bank;
    logic [CH_W-1:0]      irq_chan;
    logic                 irq_ack;
    logic [NUM_LINES-1:0] irq_pend;

    modport master (
        output irq_in, bank_en, mask_we, mask_wdata, irq_ack,
        input  irq_valid, irq_bank, irq_chan, irq_pend
    );

    modport slave (
        input  irq_in, bank_en, mask_we, mask_wdata, irq_ack,
        output irq_valid, irq_bank, irq_chan, irq_pend
    );
endinterface

// File: rtl/irq_bank_prio_ctrl.sv
// Banked interrupt controller: edge-captured sticky pending bits, mask, bank enables, fixed bank priority.
// Define IRQ_BANK_ROTATE_EN for round-robin channel selection inside each bank.
module irq_bank_prio_ctrl #(
    parameter int NUM_CH    = 9,
    parameter int NUM_BANKS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    irq_bank_prio_if.slave        bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int NL     = NUM_BANKS * NUM_CH;

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    state_t            r_state;
    logic              r_valid;
    logic [BANK_W-1:0] r_bank;
    logic [CH_W-1:0]   r_chan;
    logic [NL-1:0]     r_prev;
    logic [NL-1:0]     r_pend;
    logic [NL-1:0]     r_mask;

    logic [NL-1:0]     w_elig;
    logic [NL-1:0]     w_rise;
    logic [NL-1:0]     w_clr;
    logic              w_ack;
    logic              w_any;
    logic [BANK_W-1:0] w_bank;
    logic [CH_W-1:0]   w_chan;

    function automatic logic bit_at(input logic [NL-1:0] vec, input int pos);
        return |(vec & (NL'(1) << pos));
    endfunction

    function automatic int wrap_ch(input int base, input int offs);
        return (base + offs >= NUM_CH) ? base + offs - NUM_CH : base + offs;
    endfunction

    always_comb begin
        w_elig = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_elig[b*NUM_CH +: NUM_CH] = r_pend[b*NUM_CH +: NUM_CH] & ~r_mask[b*NUM_CH +: NUM_CH]
                                         & {NUM_CH{bus.bank_en[b]}};
        end
    end

    assign w_ack  = (r_state == PRESENT) && bus.irq_ack;
    assign w_rise = bus.irq_in & ~r_prev;
    assign w_clr  = w_ack ? (NL'(1) << (int'(r_bank) * NUM_CH + int'(r_chan))) : '0;

`ifdef IRQ_BANK_ROTATE_EN
    logic [CH_W-1:0] r_ptr [NUM_BANKS];

    // The next search in a bank starts just past the channel that was last acknowledged there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
        end else if (w_ack) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (BANK_W'(b) == r_bank)
                    r_ptr[b] <= (r_chan == CH_W'(NUM_CH - 1)) ? '0 : r_chan + 1'b1;
            end
        end
    end

    always_comb begin
        w_any  = 1'b0;
        w_bank = '0;
        w_chan = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_any && bit_at(w_elig, b * NUM_CH + wrap_ch(int'(r_ptr[b]), k))) begin
                    w_any  = 1'b1;
                    w_bank = BANK_W'(b);
                    w_chan = CH_W'(wrap_ch(int'(r_ptr[b]), k));
                end
            end
        end
    end
`else
    always_comb begin
        w_any  = 1'b0;
        w_bank = '0;
        w_chan = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_any && bit_at(w_elig, b * NUM_CH + wrap_ch(0, k))) begin
                    w_any  = 1'b1;
                    w_bank = BANK_W'(b);
                    w_chan = CH_W'(k);
                end
            end
        end
    end
`endif

    // A new edge on the line being cleared re-sets it in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            r_prev <= bus.irq_in;
            r_pend <= (r_pend & ~w_clr) | w_rise;
            if (bus.mask_we) r_mask <= bus.mask_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_bank  <= '0;
            r_chan  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= PRESENT;
                        r_valid <= 1'b1;
                        r_bank  <= w_bank;
                        r_chan  <= w_chan;
                    end
                end
                PRESENT: begin
                    if (bus.irq_ack) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_valid = r_valid;
    assign bus.irq_bank  = r_bank;
    assign bus.irq_chan  = r_chan;
    assign bus.irq_pend  = r_pend;
endmodule

// File: tb/tb_irq_bank_prio_ctrl.sv
// Bench for irq_bank_prio_ctrl: directed scenarios then random traffic against a cycle reference model.
// Build with IRQ_BANK_ROTATE_EN defined to check the round-robin variant.
module tb_irq_bank_prio_ctrl;
    localparam int NCH = 9;
    localparam int NB  = 3;
    localparam int NL  = NCH * NB;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    irq_bank_prio_if #(.NUM_CH(NCH), .NUM_BANKS(NB)) bus ();

    irq_bank_prio_ctrl #(.NUM_CH(NCH), .NUM_BANKS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: what the controller should hold, derived from its documented rules.
    logic [NL-1:0] m_pend, m_prev, m_mask;
    bit            m_valid;
    int            m_bank, m_chan;
    int            m_ptr [NB];

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mask = '0;
        m_valid = 0; m_bank = 0; m_chan = 0;
        for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    endtask

    task automatic model_update();
        logic [NL-1:0] rise;
        bit found;
        int c;
        rise = bus.irq_in & ~m_prev;
        if (!m_valid) begin
            found = 0;
            for (int b = 0; b < NB; b++) begin
                for (int k = 0; k < NCH; k++) begin
`ifdef IRQ_BANK_ROTATE_EN
                    c = (m_ptr[b] + k) % NCH;
`else
                    c = k;
`endif
                    if (!found && bus.bank_en[b] && m_pend[b*NCH+c] && !m_mask[b*NCH+c]) begin
                        found = 1; m_bank = b; m_chan = c;
                    end
                end
            end
            if (found) m_valid = 1;
        end else if (bus.irq_ack) begin
            m_pend[m_bank*NCH+m_chan] = 1'b0;
            m_ptr[m_bank] = (m_chan + 1) % NCH;
            m_valid = 0;
        end
        m_pend = m_pend | rise;
        m_prev = bus.irq_in;
        if (bus.mask_we) m_mask = bus.mask_wdata;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("valid", 32'(bus.irq_valid), 32'(m_valid));
        check("bank", 32'(bus.irq_bank), 32'(m_bank));
        check("chan", 32'(bus.irq_chan), 32'(m_chan));
        check("pend", 32'(bus.irq_pend), 32'(m_pend));
    endtask

    task automatic expect_grant(input string tag, input int b, input int c);
        check({tag, "_valid"}, 32'(bus.irq_valid), 32'd1);
        check({tag, "_bank"}, 32'(bus.irq_bank), 32'(b));
        check({tag, "_chan"}, 32'(bus.irq_chan), 32'(c));
    endtask

    task automatic ack_once();
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
    endtask

    int exp_seq [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.irq_in = '0; bus.bank_en = '1; bus.mask_we = 1'b0; bus.mask_wdata = '0; bus.irq_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.irq_valid), 32'd0);
        check("rst_bank", 32'(bus.irq_bank), 32'd0);
        check("rst_chan", 32'(bus.irq_chan), 32'd0);
        check("rst_pend", 32'(bus.irq_pend), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pulse on line 13 -> (1,4) two edges later.
        bus.irq_in = NL'(1) << 13;
        step();
        bus.irq_in = '0;
        check("p13_pend", 32'(bus.irq_pend), 32'(1) << 13);
        check("p13_early", 32'(bus.irq_valid), 32'd0);
        step();
        expect_grant("p13", 1, 4);
        ack_once();
        check("p13_ackv", 32'(bus.irq_valid), 32'd0);
        check("p13_ackp", 32'(bus.irq_pend), 32'd0);

        // Three lines at once -> (0,5), (0,7), (2,2) with one idle cycle between.
        bus.irq_in = (NL'(1) << 20) | (NL'(1) << 5) | (NL'(1) << 7);
        step();
        bus.irq_in = '0;
        step();
        expect_grant("g1", 0, 5);
        ack_once();
        check("gap1", 32'(bus.irq_valid), 32'd0);
        step();
        expect_grant("g2", 0, 7);
        ack_once();
        check("gap2", 32'(bus.irq_valid), 32'd0);
        step();
        expect_grant("g3", 2, 2);
        ack_once();

        // Masked line waits; unmasking releases it.
        bus.mask_we = 1'b1; bus.mask_wdata = NL'(1) << 5;
        step();
        bus.mask_we = 1'b0;
        bus.irq_in = (NL'(1) << 5) | (NL'(1) << 11);
        step();
        bus.irq_in = '0;
        step();
        expect_grant("mask", 1, 2);
        ack_once();
        step();
        check("masked_idle", 32'(bus.irq_valid), 32'd0);
        check("masked_pend", 32'(bus.irq_pend), 32'(1) << 5);
        bus.mask_we = 1'b1; bus.mask_wdata = '0;
        step();
        bus.mask_we = 1'b0;
        step();
        expect_grant("unmask", 0, 5);
        ack_once();
        bus.bank_en = 3'b110;
        bus.irq_in = NL'(1) << 3;
        step();
        bus.irq_in = '0;
        step();
        step();
        check("bank_off", 32'(bus.irq_valid), 32'd0);
        bus.bank_en = 3'b111;
        step();
        expect_grant("bank_on", 0, 3);
        ack_once();

        // Presented winner stays put while a higher-priority line arrives.
        bus.irq_in = NL'(1) << 11;
        step();
        bus.irq_in = '0;
        step();
        expect_grant("hold", 1, 2);
        bus.irq_in = NL'(1) << 0;
        step();
        bus.irq_in = '0;
        repeat (3) step();
        expect_grant("hold_late", 1, 2);
        ack_once();
        step();
        expect_grant("after_hold", 0, 0);
        ack_once();

        // New edge coincident with ack of the same line keeps it pending.
        bus.irq_in = NL'(1) << 11;
        step();
        bus.irq_in = '0;
        step();
        expect_grant("re0", 1, 2);
        bus.irq_in = NL'(1) << 11;
        ack_once();
        bus.irq_in = '0;
        check("re_pend", 32'(bus.irq_pend[11]), 32'd1);
        check("re_gap", 32'(bus.irq_valid), 32'd0);
        step();
        expect_grant("re1", 1, 2);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.irq_valid), 32'd0);
        check("arst_bank", 32'(bus.irq_bank), 32'd0);
        check("arst_chan", 32'(bus.irq_chan), 32'd0);
        check("arst_pend", 32'(bus.irq_pend), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Bank 0 channels 1 and 3 re-pend on every ack.
`ifdef IRQ_BANK_ROTATE_EN
        exp_seq = '{1, 3, 1, 3};
`else
        exp_seq = '{1, 1, 1, 1};
`endif
        bus.irq_in = (NL'(1) << 1) | (NL'(1) << 3);
        step();
        bus.irq_in = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            expect_grant($sformatf("rot%0d", i), 0, exp_seq[i]);
            bus.irq_in = NL'(1) << bus.irq_chan;
            ack_once();
            bus.irq_in = '0;
            step();
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            bus.irq_in     = NL'($urandom & $urandom & $urandom);
            bus.bank_en    = ($urandom_range(0, 5) == 0) ? NB'($urandom) : '1;
            bus.mask_we    = ($urandom_range(0, 15) == 0);
            bus.mask_wdata = NL'($urandom & $urandom);
            bus.irq_ack    = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
